// File: rtl/apb_master.sv
// APB requester: runs one local valid/ready command as a single SETUP+ACCESS transfer
// and returns a one-cycle response. Optional ACCESS timeout under `APB_MASTER_TIMEOUT_EN.
module apb_master #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESETn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PWRITE,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_master: TIMEOUT_CYCLES must be at least 1");
  end

  state_t                state_q, state_d;
  logic                  psel_d, penable_d, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_d;
  logic                  rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_d;

  // Only combinational output: reset forces it low even before the first edge.
  assign cmd_ready = (state_q == IDLE) && PRESETn;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             rsp_err_d;

  assign cnt_inc = cnt_q + 1'b1;
`else
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    psel_d      = PSEL;
    penable_d   = PENABLE;
    pwrite_d    = PWRITE;
    paddr_d     = PADDR;
    pwdata_d    = PWDATA;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata;
`ifdef APB_MASTER_TIMEOUT_EN
    cnt_d       = cnt_q;
    rsp_err_d   = rsp_err;
`endif
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_d  = cmd_write;
          paddr_d   = cmd_addr;
          if (cmd_write) pwdata_d = cmd_wdata;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ACCESS: begin
        if (PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = PWRITE ? '0 : PRDATA;
          state_d     = IDLE;
`ifdef APB_MASTER_TIMEOUT_EN
          rsp_err_d   = 1'b0;
`endif
        end
`ifdef APB_MASTER_TIMEOUT_EN
        // The edge on which the low-PREADY count would reach the limit aborts.
        else if (cnt_inc == CNT_W'(TIMEOUT_CYCLES)) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          cnt_d       = cnt_inc;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end
      default: begin
        psel_d    = 1'b0;
        penable_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= IDLE;
      PSEL      <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      PSEL      <= psel_d;
      PENABLE   <= penable_d;
      PWRITE    <= pwrite_d;
      PADDR     <= paddr_d;
      PWDATA    <= pwdata_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
    end
  end

`ifdef APB_MASTER_TIMEOUT_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt_q   <= '0;
      rsp_err <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      rsp_err <= rsp_err_d;
    end
  end
`endif

endmodule
